// File: rtl/hp1349a_pkg.sv
// Shared definitions for the HP1349A command scheduler: word fields, opcodes,
// sequencer state encoding and counter widths.
package hp1349a_pkg;

    localparam int unsigned WORD_W     = 16;
    localparam int unsigned COORD_W    = 11;
    localparam int unsigned CHR_W      = 8;
    localparam int unsigned COND_W     = 11;
    localparam int unsigned CMD_CNT_W  = 16;
    localparam int unsigned DROP_CNT_W = 8;

    localparam int unsigned OP_HI      = 14;
    localparam int unsigned OP_LO      = 13;
    localparam int unsigned PLOT_Y_BIT = 12;
    localparam int unsigned BEAM_BIT   = 11;

    localparam logic [1:0] OP_PLOT  = 2'b00;
    localparam logic [1:0] OP_GRAPH = 2'b01;
    localparam logic [1:0] OP_TEXT  = 2'b10;
    localparam logic [1:0] OP_COND  = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        VEC    = 3'd3,
        CHR    = 3'd4
    } state_e;

    function automatic logic [1:0] word_op(input logic [WORD_W-1:0] w);
        return w[OP_HI:OP_LO];
    endfunction

endpackage

// File: rtl/hp1349a_req_hs.sv
// Request holder: raises req on start, holds it until ack or until ACK_TMO
// cycles pass without one; done/timeout are same-cycle strobes to the sequencer.
module hp1349a_req_hs #(
    parameter int unsigned ACK_TMO = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic ack_i,
    output logic req_o,
    output logic done_c_o,
    output logic tmo_c_o
);

    localparam int unsigned CNT_W = $clog2(ACK_TMO + 1);

    logic             req_q, req_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // An ack seen in the first cycle of req is accepted like any other.
    assign done_c_o = req_q & ack_i;
    assign tmo_c_o  = req_q & ~ack_i & (cnt_q == CNT_W'(ACK_TMO - 1));
    assign req_o    = req_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            req_q <= req_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        req_d = req_q;
        cnt_d = cnt_q;
        if (start_i) begin
            req_d = 1'b1;
            cnt_d = '0;
        end else if (done_c_o || tmo_c_o) begin
            req_d = 1'b0;
            cnt_d = '0;
        end else if (req_q) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hp1349a_cmd_sched.sv
// HP1349A command scheduler: pops receive-FIFO words, tracks beam and condition
// state, and issues one request at a time to the vector or character engine.
// Optional statistics ports/counters: define HP1349A_SCHED_STATS_EN.
module hp1349a_cmd_sched
    import hp1349a_pkg::*;
#(
    parameter int unsigned GRAPH_DX = 1,
    parameter int unsigned ACK_TMO  = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [WORD_W-1:0]     fifo_rd_data,
    output logic                  vec_req,
    input  logic                  vec_ack,
    output logic [COORD_W-1:0]    vec_x,
    output logic [COORD_W-1:0]    vec_y,
    output logic                  vec_beam,
    output logic                  chr_req,
    input  logic                  chr_ack,
    output logic [CHR_W-1:0]      chr_code,
    output logic [COND_W-1:0]     cond,
    output logic                  tmo_err
`ifdef HP1349A_SCHED_STATS_EN
    ,
    output logic [CMD_CNT_W-1:0]  cmd_cnt,
    output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

    state_e               state_q, state_d;
    logic                 rd_en_q, rd_en_d;
    logic [COORD_W-1:0]   x_q, x_d;
    logic [COORD_W-1:0]   y_q, y_d;
    logic                 beam_q, beam_d;
    logic [COORD_W-1:0]   x_pend_q, x_pend_d;
    logic                 pend_vld_q, pend_vld_d;
    logic [CHR_W-1:0]     chr_code_q, chr_code_d;
    logic [COND_W-1:0]    cond_q, cond_d;
    logic                 tmo_err_q, tmo_err_d;

    logic                 vec_start_c, chr_start_c;
    logic                 vec_done_c, vec_tmo_c;
    logic                 chr_done_c, chr_tmo_c;
    logic [COORD_W-1:0]   coord_c;
    logic                 unused_msb;

    assign coord_c    = fifo_rd_data[COORD_W-1:0];
    assign unused_msb = fifo_rd_data[WORD_W-1];

    hp1349a_req_hs #(.ACK_TMO(ACK_TMO)) u_vec_hs (
        .clk      (clk),
        .rst      (rst),
        .start_i  (vec_start_c),
        .ack_i    (vec_ack),
        .req_o    (vec_req),
        .done_c_o (vec_done_c),
        .tmo_c_o  (vec_tmo_c)
    );

    hp1349a_req_hs #(.ACK_TMO(ACK_TMO)) u_chr_hs (
        .clk      (clk),
        .rst      (rst),
        .start_i  (chr_start_c),
        .ack_i    (chr_ack),
        .req_o    (chr_req),
        .done_c_o (chr_done_c),
        .tmo_c_o  (chr_tmo_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rd_en_q    <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            beam_q     <= 1'b0;
            x_pend_q   <= '0;
            pend_vld_q <= 1'b0;
            chr_code_q <= '0;
            cond_q     <= '0;
            tmo_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_en_q    <= rd_en_d;
            x_q        <= x_d;
            y_q        <= y_d;
            beam_q     <= beam_d;
            x_pend_q   <= x_pend_d;
            pend_vld_q <= pend_vld_d;
            chr_code_q <= chr_code_d;
            cond_q     <= cond_d;
            tmo_err_q  <= tmo_err_d;
        end
    end

    // The popped word is presented by the FIFO in DECODE, the cycle after the strobe.
    always_comb begin
        state_d     = state_q;
        rd_en_d     = 1'b0;
        x_d         = x_q;
        y_d         = y_q;
        beam_d      = beam_q;
        x_pend_d    = x_pend_q;
        pend_vld_d  = pend_vld_q;
        chr_code_d  = chr_code_q;
        cond_d      = cond_q;
        tmo_err_d   = tmo_err_q | vec_tmo_c | chr_tmo_c;
        vec_start_c = 1'b0;
        chr_start_c = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    rd_en_d = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: state_d = DECODE;
            DECODE: begin
                case (word_op(fifo_rd_data))
                    OP_PLOT: begin
                        if (!fifo_rd_data[PLOT_Y_BIT]) begin
                            x_pend_d   = coord_c;
                            pend_vld_d = 1'b1;
                            state_d    = IDLE;
                        end else begin
                            x_d         = pend_vld_q ? x_pend_q : x_q;
                            y_d         = coord_c;
                            beam_d      = fifo_rd_data[BEAM_BIT];
                            pend_vld_d  = 1'b0;
                            vec_start_c = 1'b1;
                            state_d     = VEC;
                        end
                    end
                    OP_GRAPH: begin
                        x_d         = x_q + COORD_W'(GRAPH_DX);
                        y_d         = coord_c;
                        beam_d      = 1'b1;
                        vec_start_c = 1'b1;
                        state_d     = VEC;
                    end
                    OP_TEXT: begin
                        chr_code_d  = fifo_rd_data[CHR_W-1:0];
                        chr_start_c = 1'b1;
                        state_d     = CHR;
                    end
                    OP_COND: begin
                        cond_d  = fifo_rd_data[COND_W-1:0];
                        state_d = IDLE;
                    end
                    default: state_d = IDLE;
                endcase
            end
            VEC: begin
                if (vec_done_c || vec_tmo_c) begin
                    state_d = IDLE;
                end
            end
            CHR: begin
                if (chr_done_c || chr_tmo_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign fifo_rd_en = rd_en_q;
    assign vec_x      = x_q;
    assign vec_y      = y_q;
    assign vec_beam   = beam_q;
    assign chr_code   = chr_code_q;
    assign cond       = cond_q;
    assign tmo_err    = tmo_err_q;

`ifdef HP1349A_SCHED_STATS_EN
    logic [CMD_CNT_W-1:0]  cmd_cnt_q;
    logic [DROP_CNT_W-1:0] drop_cnt_q;
    logic                  cmd_done_c;

    // Commands complete on acceptance, or at decode when they issue no request.
    assign cmd_done_c = vec_done_c | chr_done_c |
                        ((state_q == DECODE) && (word_op(fifo_rd_data) == OP_COND)) |
                        ((state_q == DECODE) && (word_op(fifo_rd_data) == OP_PLOT) &&
                         !fifo_rd_data[PLOT_Y_BIT]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (cmd_done_c) begin
                cmd_cnt_q <= cmd_cnt_q + CMD_CNT_W'(1);
            end
            if ((vec_tmo_c || chr_tmo_c) && (drop_cnt_q != {DROP_CNT_W{1'b1}})) begin
                drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
            end
        end
    end

    assign cmd_cnt  = cmd_cnt_q;
    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_hp1349a_cmd_sched.sv
// Directed bench for hp1349a_cmd_sched with a small registered-read FIFO model.
module tb_hp1349a_cmd_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [15:0] fifo_rd_data = '0;
    logic        vec_req;
    logic        vec_ack = 1'b0;
    logic [10:0] vec_x;
    logic [10:0] vec_y;
    logic        vec_beam;
    logic        chr_req;
    logic        chr_ack = 1'b0;
    logic [7:0]  chr_code;
    logic [10:0] cond;
    logic        tmo_err;
`ifdef HP1349A_SCHED_STATS_EN
    logic [15:0] cmd_cnt;
    logic [7:0]  drop_cnt;
`endif

    logic [15:0] mem [0:255];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr);

    // Registered read: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (fifo_rd_en && (wr_ptr != rd_ptr)) begin
            fifo_rd_data <= mem[rd_ptr];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    hp1349a_cmd_sched dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .vec_req      (vec_req),
        .vec_ack      (vec_ack),
        .vec_x        (vec_x),
        .vec_y        (vec_y),
        .vec_beam     (vec_beam),
        .chr_req      (chr_req),
        .chr_ack      (chr_ack),
        .chr_code     (chr_code),
        .cond         (cond),
        .tmo_err      (tmo_err)
`ifdef HP1349A_SCHED_STATS_EN
        ,
        .cmd_cnt      (cmd_cnt),
        .drop_cnt     (drop_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [15:0] w);
        mem[wr_ptr] = w;
        wr_ptr      = wr_ptr + 1;
    endtask

    // Bounded wait for a request; sel 0 = vector, 1 = character.
    task automatic wait_req(input bit sel, input int max);
        int n;
        n = 0;
        while (!(sel ? chr_req : vec_req) && n < max) begin
            step(1);
            n++;
        end
    endtask

    task automatic ack_vec();
        vec_ack = 1'b1;
        step(1);
        vec_ack = 1'b0;
    endtask

    task automatic ack_chr();
        chr_ack = 1'b1;
        step(1);
        chr_ack = 1'b0;
    endtask

    initial begin
        int  n;
        bit  any_req;

        // Reset state
        step(2);
        chk("rst_vec_req", 32'(vec_req), 0);
        chk("rst_rd_en", 32'(fifo_rd_en), 0);
        chk("rst_vec_x", 32'(vec_x), 0);
        chk("rst_tmo", 32'(tmo_err), 0);
        rst = 1'b0;
        step(3);
        chk("idle_empty_rd_en", 32'(fifo_rd_en), 0);

        // Plot X=100 then Y=50 beam on
        push(16'h0064);
        push(16'h1832);
        wait_req(1'b0, 20);
        chk("plot_req", 32'(vec_req), 1);
        chk("plot_x", 32'(vec_x), 100);
        chk("plot_y", 32'(vec_y), 50);
        chk("plot_beam", 32'(vec_beam), 1);
        step(5);
        chk("plot_req_held", 32'(vec_req), 1);
        ack_vec();
        chk("plot_req_drop", 32'(vec_req), 0);

        // Graph words: exact pop-to-request latency, then x increments
        push(16'h2010);
        step(2);
        chk("graph1_req_early", 32'(vec_req), 0);
        step(1);
        chk("graph1_req", 32'(vec_req), 1);
        chk("graph1_x", 32'(vec_x), 101);
        chk("graph1_y", 32'(vec_y), 16);
        chk("graph1_beam", 32'(vec_beam), 1);
        ack_vec();
        push(16'h2020);
        wait_req(1'b0, 20);
        chk("graph2_x", 32'(vec_x), 102);
        chk("graph2_y", 32'(vec_y), 32);
        ack_vec();

        // Text command
        push(16'h4041);
        wait_req(1'b1, 20);
        chk("text_req", 32'(chr_req), 1);
        chk("text_code", 32'(chr_code), 32'h41);
        chk("text_no_vec", 32'(vec_req), 0);
        ack_chr();
        chk("text_req_drop", 32'(chr_req), 0);

        // Set condition: no request issued
        push(16'h6155);
        any_req = 1'b0;
        step(2);
        any_req = any_req | vec_req | chr_req;
        chk("cond_early", 32'(cond), 0);
        step(1);
        any_req = any_req | vec_req | chr_req;
        chk("cond_val", 32'(cond), 32'h155);
        step(3);
        any_req = any_req | vec_req | chr_req;
        chk("cond_no_req", 32'(any_req), 0);

        // Ack held while idle is ignored; ack in the rise cycle is accepted
        chr_ack = 1'b1;
        step(2);
        chk("idle_ack_ignored", 32'(chr_req), 0);
        push(16'h4042);
        step(3);
        chk("same_cycle_req", 32'(chr_req), 1);
        chk("same_cycle_code", 32'(chr_code), 32'h42);
        step(1);
        chk("same_cycle_drop", 32'(chr_req), 0);
        chr_ack = 1'b0;

        // X=5, X=7, Y=9 beam off: one vector at x=7
        push(16'h0005);
        push(16'h0007);
        push(16'h1009);
        wait_req(1'b0, 40);
        chk("xx_req", 32'(vec_req), 1);
        chk("xx_x", 32'(vec_x), 7);
        chk("xx_y", 32'(vec_y), 9);
        chk("xx_beam", 32'(vec_beam), 0);
        ack_vec();
        any_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            any_req = any_req | vec_req;
        end
        chk("xx_single_vec", 32'(any_req), 0);

        // Y with no pending X keeps the committed x
        push(16'h1803);
        wait_req(1'b0, 20);
        chk("y_only_x", 32'(vec_x), 7);
        chk("y_only_y", 32'(vec_y), 3);
        ack_vec();

        // Graph x wraps from 2047 to 0
        push(16'h07FF);
        push(16'h1800);
        wait_req(1'b0, 20);
        chk("wrap_pre_x", 32'(vec_x), 2047);
        ack_vec();
        push(16'h2005);
        wait_req(1'b0, 20);
        chk("wrap_x", 32'(vec_x), 0);
        chk("wrap_y", 32'(vec_y), 5);
        ack_vec();

        // Timeout: request held 255 cycles, then sticky error
        chk("tmo_before", 32'(tmo_err), 0);
        push(16'h000A);
        push(16'h180B);
        wait_req(1'b0, 20);
        chk("tmo_req", 32'(vec_req), 1);
        n = 0;
        while (vec_req && n < 400) begin
            step(1);
            n++;
        end
        chk("tmo_hold_cycles", 32'(n), 255);
        chk("tmo_err_set", 32'(tmo_err), 1);
        push(16'h4043);
        wait_req(1'b1, 20);
        chk("tmo_next_code", 32'(chr_code), 32'h43);
        ack_chr();
        chk("tmo_err_sticky", 32'(tmo_err), 1);

        // Reset mid-request, with a pending X held inside
        push(16'h0011);
        push(16'h1812);
        wait_req(1'b0, 20);
        ack_vec();
        push(16'h0033);
        step(4);
        push(16'h2001);
        wait_req(1'b0, 20);
        chk("pre_rst_x", 32'(vec_x), 32'h12);
        chk("pre_rst_req", 32'(vec_req), 1);
        rst = 1'b1;
        #1;
        chk("rst_async_req", 32'(vec_req), 0);
        chk("rst_async_x", 32'(vec_x), 0);
        chk("rst_async_y", 32'(vec_y), 0);
        chk("rst_async_cond", 32'(cond), 0);
        chk("rst_async_tmo", 32'(tmo_err), 0);
        step(2);
        rst = 1'b0;
        any_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            any_req = any_req | fifo_rd_en;
        end
        chk("rst_empty_rd_en", 32'(any_req), 0);
        push(16'h1804);
        wait_req(1'b0, 20);
        chk("rst_pend_drop_x", 32'(vec_x), 0);
        chk("rst_pend_drop_y", 32'(vec_y), 4);
        ack_vec();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
